// File: rtl/pcie_rq_arbiter.sv
// Two-input, packet-atomic AXI-stream arbiter feeding the PCIe RQ interface.
// Port 1 (ATS completions) has priority; port 0 (DMA requests) is guaranteed a grant after a run of port-1 packets.
module pcie_rq_arbiter #(
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int RQ_TUSER_WIDTH  = 137,
    parameter int MAX_HI_PKTS     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [AXIS_DATA_WIDTH-1:0]   s0_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] s0_axis_tkeep,
    input  logic                         s0_axis_tvalid,
    input  logic                         s0_axis_tlast,
    input  logic [RQ_TUSER_WIDTH-1:0]    s0_axis_tuser,
    output logic                         s0_axis_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]   s1_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] s1_axis_tkeep,
    input  logic                         s1_axis_tvalid,
    input  logic                         s1_axis_tlast,
    output logic                         s1_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    output logic [RQ_TUSER_WIDTH-1:0]    m_axis_tuser,
    input  logic                         m_axis_tready,
    output logic [1:0]                   grant_state,
    output logic [31:0]                  pkt_cnt_s0,
    output logic [31:0]                  pkt_cnt_s1,
    output logic                         starve_evt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;
    localparam logic [7:0] HI_MAX  = 8'(MAX_HI_PKTS);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [7:0] hi_cnt;
    logic [7:0] hi_cnt_nxt;
    logic       starve_nxt;
    logic       starve_win;
    logic       s0_done;
    logic       s1_done;

    function automatic logic [7:0] hi_sat_inc(input logic [7:0] v);
        return (v >= HI_MAX) ? HI_MAX : v + 8'd1;
    endfunction

    // Port 0 overrides port 1 once it has waited through MAX_HI_PKTS port-1 packets.
    assign starve_win = s0_axis_tvalid && (hi_cnt == HI_MAX);
    assign s0_done    = (state == ST_GNT0) && s0_axis_tvalid && m_axis_tready && s0_axis_tlast;
    assign s1_done    = (state == ST_GNT1) && s1_axis_tvalid && m_axis_tready && s1_axis_tlast;

    always_comb begin
        state_nxt  = state;
        hi_cnt_nxt = hi_cnt;
        starve_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s1_axis_tvalid && !starve_win) begin
                    state_nxt  = ST_GNT1;
                    hi_cnt_nxt = s0_axis_tvalid ? hi_sat_inc(hi_cnt) : 8'd0;
                end else if (s0_axis_tvalid) begin
                    state_nxt  = ST_GNT0;
                    hi_cnt_nxt = 8'd0;
                    starve_nxt = s1_axis_tvalid;
                end
            end
            ST_GNT0: if (s0_done) state_nxt = ST_IDLE;
            ST_GNT1: if (s1_done) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            hi_cnt     <= 8'd0;
            starve_evt <= 1'b0;
            pkt_cnt_s0 <= 32'd0;
            pkt_cnt_s1 <= 32'd0;
        end else begin
            state      <= state_nxt;
            hi_cnt     <= hi_cnt_nxt;
            starve_evt <= starve_nxt;
            if (s0_done) pkt_cnt_s0 <= pkt_cnt_s0 + 32'd1;
            if (s1_done) pkt_cnt_s1 <= pkt_cnt_s1 + 32'd1;
        end
    end

    // Zero-latency output mux; IDLE presents an all-zero, invalid bus.
    always_comb begin
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        m_axis_tdata   = '0;
        m_axis_tkeep   = '0;
        m_axis_tvalid  = 1'b0;
        m_axis_tlast   = 1'b0;
        m_axis_tuser   = '0;
        case (state)
            ST_GNT0: begin
                s0_axis_tready = m_axis_tready;
                m_axis_tdata   = s0_axis_tdata;
                m_axis_tkeep   = s0_axis_tkeep;
                m_axis_tvalid  = s0_axis_tvalid;
                m_axis_tlast   = s0_axis_tlast;
                m_axis_tuser   = s0_axis_tuser;
            end
            ST_GNT1: begin
                s1_axis_tready = m_axis_tready;
                m_axis_tdata   = s1_axis_tdata;
                m_axis_tkeep   = s1_axis_tkeep;
                m_axis_tvalid  = s1_axis_tvalid;
                m_axis_tlast   = s1_axis_tlast;
            end
            default: ;
        endcase
    end

    assign grant_state = state;

endmodule

// File: tb/tb_pcie_rq_arbiter.sv
// Scoreboard bench for pcie_rq_arbiter: directed arbitration scenarios followed by random traffic.
module tb_pcie_rq_arbiter;

    localparam int DW   = 32;
    localparam int KW   = DW / 8;
    localparam int TU   = 8;
    localparam int MAXH = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [TU-1:0] user;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s0_tdata;
    logic [KW-1:0] s0_tkeep;
    logic          s0_tvalid;
    logic          s0_tlast;
    logic [TU-1:0] s0_tuser;
    logic          s0_tready;
    logic [DW-1:0] s1_tdata;
    logic [KW-1:0] s1_tkeep;
    logic          s1_tvalid;
    logic          s1_tlast;
    logic          s1_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tvalid;
    logic          m_tlast;
    logic [TU-1:0] m_tuser;
    logic          m_tready;
    logic [1:0]    grant_state;
    logic [31:0]   pkt_cnt_s0;
    logic [31:0]   pkt_cnt_s1;
    logic          starve_evt;

    pcie_rq_arbiter #(
        .AXIS_DATA_WIDTH(DW),
        .RQ_TUSER_WIDTH (TU),
        .MAX_HI_PKTS    (MAXH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s0_axis_tdata (s0_tdata),
        .s0_axis_tkeep (s0_tkeep),
        .s0_axis_tvalid(s0_tvalid),
        .s0_axis_tlast (s0_tlast),
        .s0_axis_tuser (s0_tuser),
        .s0_axis_tready(s0_tready),
        .s1_axis_tdata (s1_tdata),
        .s1_axis_tkeep (s1_tkeep),
        .s1_axis_tvalid(s1_tvalid),
        .s1_axis_tlast (s1_tlast),
        .s1_axis_tready(s1_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .m_axis_tready (m_tready),
        .grant_state   (grant_state),
        .pkt_cnt_s0    (pkt_cnt_s0),
        .pkt_cnt_s1    (pkt_cnt_s1),
        .starve_evt    (starve_evt)
    );

    always #5 clk = ~clk;

    beat_t tx0[$];
    beat_t tx1[$];
    beat_t ex0[$];
    beat_t ex1[$];
    int    ord_q[$];
    int    total = 0;
    int    bad = 0;
    int    seq = 0;
    int    starve_n = 0;
    int    gap_pct = 0;
    int    rdy_mode = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack(input beat_t b);
        return 64'({b.data, b.keep, b.last, b.user});
    endfunction

    // Payload top bit carries the source port so the monitor can route each beat.
    task automatic push_pkt(input int port, input int nb);
        beat_t b;
        for (int i = 0; i < nb; i++) begin
            seq++;
            b.data = {port[0], seq[DW-2:0]};
            b.keep = KW'($urandom_range(15, 1));
            b.last = (i == nb - 1);
            b.user = (port == 0) ? TU'($urandom) : '0;
            if (port == 0) begin
                tx0.push_back(b);
                ex0.push_back(b);
            end else begin
                tx1.push_back(b);
                ex1.push_back(b);
            end
        end
    endtask

    task automatic drain(input string tag, input int maxc);
        int c;
        c = 0;
        while ((tx0.size() + tx1.size() + ex0.size() + ex1.size()) != 0 && c < maxc) begin
            @(negedge clk);
            c++;
        end
        chk(tag, 64'(c < maxc), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_hs(input string tag);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(m_tvalid && m_tready && grant_state == 2'd1) && c < 40);
        chk(tag, 64'(c < 40), 64'd1);
    endtask

    initial begin : drv0
        bit    fire;
        beat_t b;
        s0_tvalid = 1'b0; s0_tdata = '0; s0_tkeep = '0; s0_tlast = 1'b0; s0_tuser = '0;
        forever begin
            @(negedge clk);
            fire = s0_tvalid && s0_tready;
            @(posedge clk);
            #1;
            if (rst) begin
                tx0.delete();
                s0_tvalid = 1'b0;
            end else begin
                if (fire && tx0.size() > 0) begin
                    b = tx0.pop_front();
                    s0_tvalid = 1'b0;
                end
                if (!s0_tvalid && tx0.size() > 0 && $urandom_range(99) >= gap_pct) begin
                    b = tx0[0];
                    s0_tvalid = 1'b1; s0_tdata = b.data; s0_tkeep = b.keep;
                    s0_tlast = b.last; s0_tuser = b.user;
                end
            end
        end
    end

    initial begin : drv1
        bit    fire;
        beat_t b;
        s1_tvalid = 1'b0; s1_tdata = '0; s1_tkeep = '0; s1_tlast = 1'b0;
        forever begin
            @(negedge clk);
            fire = s1_tvalid && s1_tready;
            @(posedge clk);
            #1;
            if (rst) begin
                tx1.delete();
                s1_tvalid = 1'b0;
            end else begin
                if (fire && tx1.size() > 0) begin
                    b = tx1.pop_front();
                    s1_tvalid = 1'b0;
                end
                if (!s1_tvalid && tx1.size() > 0 && $urandom_range(99) >= gap_pct) begin
                    b = tx1[0];
                    s1_tvalid = 1'b1; s1_tdata = b.data; s1_tkeep = b.keep; s1_tlast = b.last;
                end
            end
        end
    end

    initial begin : drv_rdy
        m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = !m_tready;
                default: m_tready = ($urandom_range(3) != 0);
            endcase
        end
    end

    initial begin : mon
        beat_t       e;
        logic [63:0] obs;
        logic [63:0] prev;
        int          port;
        int          cur;
        bit          in_pkt;
        bit          stall;
        in_pkt = 1'b0; stall = 1'b0; prev = '0; cur = 0;
        forever begin
            @(negedge clk);
            if (starve_evt) starve_n++;
            if (rst) begin
                ex0.delete(); ex1.delete(); ord_q.delete();
                in_pkt = 1'b0;
                stall  = 1'b0;
            end else begin
                obs = 64'({m_tdata, m_tkeep, m_tlast, m_tuser});
                if (stall) chk("m_stable", {m_tvalid, obs[62:0]}, {1'b1, prev[62:0]});
                stall = m_tvalid && !m_tready;
                prev  = obs;
                if (m_tvalid && m_tready) begin
                    port = m_tdata[DW-1] ? 1 : 0;
                    if (in_pkt) chk("no_interleave", 64'(port), 64'(cur));
                    if (port == 0) begin
                        if (ex0.size() == 0) chk("sb0_unexpected_beat", 64'd0, 64'd1);
                        else begin e = ex0.pop_front(); chk("beat_s0", obs, pack(e)); end
                    end else begin
                        if (ex1.size() == 0) chk("sb1_unexpected_beat", 64'd0, 64'd1);
                        else begin e = ex1.pop_front(); chk("beat_s1", obs, pack(e)); end
                    end
                    if (m_tlast) begin
                        in_pkt = 1'b0;
                        if (ord_q.size() > 0) chk("pkt_order", 64'(port), 64'(ord_q.pop_front()));
                    end else begin
                        in_pkt = 1'b1;
                        cur    = port;
                    end
                end
            end
        end
    end

    initial begin : main
        int t;
        int n0;
        int n1;
        int s_before;
        int p;
        int nb;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_state", 64'(grant_state), 64'd0);
        chk("rst_s0_rdy", 64'(s0_tready), 64'd0);
        chk("rst_s1_rdy", 64'(s1_tready), 64'd0);
        chk("rst_m_vld", 64'(m_tvalid), 64'd0);
        chk("rst_cnt0", 64'(pkt_cnt_s0), 64'd0);
        chk("rst_cnt1", 64'(pkt_cnt_s1), 64'd0);
        chk("rst_starve", 64'(starve_evt), 64'd0);

        // s0 alone: one bubble cycle, then the packet passes through with tuser
        push_pkt(0, 3);
        t = 0;
        do begin @(negedge clk); t++; end while (!s0_tvalid && t < 20);
        chk("t1_s0_valid_seen", 64'(s0_tvalid), 64'd1);
        chk("t1_bubble_state", 64'(grant_state), 64'd0);
        chk("t1_bubble_m_vld", 64'(m_tvalid), 64'd0);
        @(negedge clk);
        chk("t1_gnt_state", 64'(grant_state), 64'd1);
        chk("t1_gnt_m_vld", 64'(m_tvalid), 64'd1);
        drain("t1_drain", 200);
        chk("t1_cnt0", 64'(pkt_cnt_s0), 64'd1);

        // simultaneous requests: port 1 first
        ord_q.push_back(1); ord_q.push_back(0);
        push_pkt(1, 1);
        push_pkt(0, 1);
        drain("t2_drain", 200);
        chk("t2_cnt1", 64'(pkt_cnt_s1), 64'd1);
        chk("t2_cnt0", 64'(pkt_cnt_s0), 64'd2);
        chk("t2_order_done", 64'(ord_q.size()), 64'd0);

        // starvation guarantee after MAXH port-1 packets
        s_before = starve_n;
        for (int i = 0; i < 4; i++) ord_q.push_back(1);
        ord_q.push_back(0); ord_q.push_back(1); ord_q.push_back(1);
        push_pkt(0, 1);
        for (int i = 0; i < 6; i++) push_pkt(1, 1);
        drain("t3_drain", 300);
        chk("t3_starve_pulses", 64'(starve_n - s_before), 64'd1);
        chk("t3_cnt0", 64'(pkt_cnt_s0), 64'd3);
        chk("t3_cnt1", 64'(pkt_cnt_s1), 64'd7);
        chk("t3_order_done", 64'(ord_q.size()), 64'd0);

        // s1 arrives mid-packet with toggling ready: grant held
        rdy_mode = 1;
        ord_q.push_back(0); ord_q.push_back(1);
        push_pkt(0, 4);
        wait_hs("t4_first_beat");
        push_pkt(1, 1);
        t = 0;
        while (grant_state == 2'd1 && t < 40) begin
            chk("t4_s1_rdy_low", 64'(s1_tready), 64'd0);
            chk("t4_s0_rdy_follows", 64'(s0_tready), 64'(m_tready));
            @(negedge clk);
            t++;
        end
        chk("t4_grant_released", 64'(t < 40), 64'd1);
        drain("t4_drain", 200);
        chk("t4_cnt0", 64'(pkt_cnt_s0), 64'd4);
        chk("t4_cnt1", 64'(pkt_cnt_s1), 64'd8);

        // reset mid-packet aborts the grant
        rdy_mode = 0;
        push_pkt(0, 4);
        wait_hs("t5_first_beat");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_state", 64'(grant_state), 64'd0);
        chk("t5_s0_rdy", 64'(s0_tready), 64'd0);
        chk("t5_s1_rdy", 64'(s1_tready), 64'd0);
        chk("t5_m_vld", 64'(m_tvalid), 64'd0);
        chk("t5_cnt0", 64'(pkt_cnt_s0), 64'd0);
        chk("t5_cnt1", 64'(pkt_cnt_s1), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // random traffic on both ports with random backpressure
        gap_pct  = 30;
        rdy_mode = 2;
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 6000; i++) begin
            p  = $urandom_range(1);
            nb = $urandom_range(4, 1);
            push_pkt(p, nb);
            if (p == 0) n0++; else n1++;
        end
        drain("t6_drain", 90000);
        chk("t6_cnt0", 64'(pkt_cnt_s0), 64'(n0));
        chk("t6_cnt1", 64'(pkt_cnt_s1), 64'(n1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
